// File: rtl/branch_target_predictor_if.sv
// Fetch/execute-side signal bundle of the branch target predictor.
// master = fetch/execute pipeline, slave = predictor.
interface branch_target_predictor_if #(
    parameter int PC_W = 13
);
    // Updates use a valid-only handshake: the predictor accepts every cycle in
    // which upd_valid is high (no ready); upd_* are sampled on that posedge only.
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] prepc;
    logic            hit_predict;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic [PC_W-1:0] upd_target;
    logic            upd_taken;
    logic            upd_mispredict;
    logic [31:0]     perf_branches;
    logic [31:0]     perf_mispred;

    modport master (
        output pc, upd_valid, upd_pc, upd_target, upd_taken, upd_mispredict,
        input  prepc, hit_predict, perf_branches, perf_mispred
    );

    modport slave (
        input  pc, upd_valid, upd_pc, upd_target, upd_taken, upd_mispredict,
        output prepc, hit_predict, perf_branches, perf_mispred
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional macro BP_PERF_CNT_EN adds resolved-branch / mispredict counters.
module branch_target_predictor #(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = 6,
    parameter int PC_W    = 13
) (
    input logic                        CLK,
    input logic                        NRST,
    branch_target_predictor_if.slave   bp
);
    localparam int TAG_W = PC_W - IDX_W;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [PC_W-1:0]   target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic              lk_hit;
    logic [IDX_W-1:0]  up_idx;
    logic [TAG_W-1:0]  up_tag;
    logic              up_match;

    assign lk_idx = bp.pc[IDX_W-1:0];
    assign lk_tag = bp.pc[PC_W-1:IDX_W];
    assign up_idx = bp.upd_pc[IDX_W-1:0];
    assign up_tag = bp.upd_pc[PC_W-1:IDX_W];

    // Lookup sees pre-update contents; no bypass from a same-cycle update.
    assign lk_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && ctr_q[lk_idx][1];
    assign bp.hit_predict = lk_hit;
    assign bp.prepc       = lk_hit ? target_q[lk_idx] : bp.pc + {{(PC_W-1){1'b0}}, 1'b1};

    assign up_match = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (bp.upd_valid) begin
            if (up_match) begin
                if (bp.upd_taken) begin
                    target_q[up_idx] <= bp.upd_target;
                    if (ctr_q[up_idx] != 2'b11) ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
                end else if (ctr_q[up_idx] != 2'b00) begin
                    ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
                end
            end else if (bp.upd_taken) begin
                // Miss on a taken branch replaces whatever lives at this index.
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= bp.upd_target;
                ctr_q[up_idx]    <= 2'b10;
            end
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_branches_q;
    logic [31:0] perf_mispred_q;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            perf_branches_q <= '0;
            perf_mispred_q  <= '0;
        end else if (bp.upd_valid) begin
            perf_branches_q <= perf_branches_q + 32'd1;
            if (bp.upd_mispredict) perf_mispred_q <= perf_mispred_q + 32'd1;
        end
    end

    assign bp.perf_branches = perf_branches_q;
    assign bp.perf_mispred  = perf_mispred_q;
`else
    logic unused_mispredict;
    assign unused_mispredict = bp.upd_mispredict;
    assign bp.perf_branches  = 32'd0;
    assign bp.perf_mispred   = 32'd0;
`endif
endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: directed scenarios plus random traffic
// checked against an array-based reference model of the prediction rules.
module tb_branch_target_predictor;
    localparam int ENTRIES = 64;
`ifdef BP_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic CLK;
    logic NRST;
    int   checks = 0;
    int   errors = 0;

    branch_target_predictor_if #(.PC_W(13)) bp_if ();

    branch_target_predictor #(.ENTRIES(64), .IDX_W(6), .PC_W(13)) dut (
        .CLK  (CLK),
        .NRST (NRST),
        .bp   (bp_if.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Reference model: one record per table slot, plain integer arithmetic.
    bit          m_valid  [ENTRIES];
    int          m_tag    [ENTRIES];
    logic [12:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    logic [31:0] m_br;
    logic [31:0] m_mp;

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = '0; m_ctr[i] = 1;
        end
        m_br = '0; m_mp = '0;
    endfunction

    function automatic void model_update(logic [12:0] pc, logic [12:0] tgt, logic taken, logic mis);
        int i, t;
        i = int'(pc) % ENTRIES;
        t = int'(pc) / ENTRIES;
        m_br = m_br + 32'd1;
        if (mis) m_mp = m_mp + 32'd1;
        if (m_valid[i] && m_tag[i] == t) begin
            if (taken) begin
                m_target[i] = tgt;
                m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (taken) begin
            m_valid[i] = 1'b1; m_tag[i] = t; m_target[i] = tgt; m_ctr[i] = 2;
        end
    endfunction

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_model_lookup();
        int i, t;
        logic exp_hit;
        logic [12:0] exp_pc;
        i = int'(bp_if.pc) % ENTRIES;
        t = int'(bp_if.pc) / ENTRIES;
        exp_hit = m_valid[i] && (m_tag[i] == t) && (m_ctr[i] >= 2);
        exp_pc  = exp_hit ? m_target[i] : 13'((int'(bp_if.pc) + 1) % 8192);
        check_val("hit_predict", {31'd0, bp_if.hit_predict}, {31'd0, exp_hit});
        check_val("prepc", {19'd0, bp_if.prepc}, {19'd0, exp_pc});
    endtask

    task automatic check_perf();
        check_val("perf_branches", bp_if.perf_branches, PERF_EN ? m_br : 32'd0);
        check_val("perf_mispred",  bp_if.perf_mispred,  PERF_EN ? m_mp : 32'd0);
    endtask

    // One clock: drive at negedge, check lookup before the edge, apply model after it.
    task automatic cycle(input logic [12:0] pc, input logic uv, input logic [12:0] upc,
                         input logic [12:0] tgt, input logic taken, input logic mis);
        bp_if.pc = pc; bp_if.upd_valid = uv; bp_if.upd_pc = upc;
        bp_if.upd_target = tgt; bp_if.upd_taken = taken; bp_if.upd_mispredict = mis;
        #1;
        check_model_lookup();
        @(posedge CLK);
        if (NRST && uv) model_update(upc, tgt, taken, mis);
        @(negedge CLK);
        check_perf();
    endtask

    task automatic expect_lookup(input string name, input logic [12:0] pc,
                                 input logic exp_hit, input logic [12:0] exp_pc);
        bp_if.pc = pc; bp_if.upd_valid = 1'b0;
        #1;
        check_val({name, "_hit"}, {31'd0, bp_if.hit_predict}, {31'd0, exp_hit});
        check_val({name, "_prepc"}, {19'd0, bp_if.prepc}, {19'd0, exp_pc});
        @(negedge CLK);
    endtask

    task automatic upd(input logic [12:0] upc, input logic [12:0] tgt, input logic taken, input logic mis);
        cycle(13'h000, 1'b1, upc, tgt, taken, mis);
    endtask

    task automatic async_reset_pulse();
        #2 NRST = 1'b0;
        model_reset();
        #1;
        check_perf();
        bp_if.upd_valid = 1'b0;
        bp_if.pc = 13'h010; #1; check_model_lookup();
        bp_if.pc = 13'h050; #1; check_model_lookup();
        // Update presented across a posedge while still in reset must be dropped.
        bp_if.upd_valid = 1'b1; bp_if.upd_pc = 13'h010; bp_if.upd_target = 13'h0AA;
        bp_if.upd_taken = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bp_if.upd_valid = 1'b0;
        NRST = 1'b1;
        bp_if.pc = 13'h010; #1; check_model_lookup();
        @(negedge CLK);
    endtask

    initial begin
        logic [12:0] rpc, rupc, rtgt;
        NRST = 1'b0;
        bp_if.pc = 13'h010; bp_if.upd_valid = 1'b0; bp_if.upd_pc = '0;
        bp_if.upd_target = '0; bp_if.upd_taken = 1'b0; bp_if.upd_mispredict = 1'b0;
        model_reset();

        // Reset state and pc+1 wrap.
        #1;
        check_val("rst_hit", {31'd0, bp_if.hit_predict}, 32'd0);
        check_val("rst_prepc", {19'd0, bp_if.prepc}, 32'h011);
        bp_if.pc = 13'h1FFF; #1;
        check_val("rst_wrap", {19'd0, bp_if.prepc}, 32'h0000);
        check_perf();
        @(negedge CLK);
        NRST = 1'b1;

        // Allocate then hit.
        upd(13'h010, 13'h080, 1'b1, 1'b0);
        expect_lookup("alloc", 13'h010, 1'b1, 13'h080);

        // Counter walk: 10 -> 01 (miss) -> 11 saturate -> 10 (hit).
        upd(13'h010, 13'h080, 1'b0, 1'b1);
        expect_lookup("ctr01", 13'h010, 1'b0, 13'h011);
        for (int k = 0; k < 3; k++) upd(13'h010, 13'h080, 1'b1, 1'b0);
        expect_lookup("ctr11", 13'h010, 1'b1, 13'h080);
        upd(13'h010, 13'h080, 1'b0, 1'b0);
        expect_lookup("ctr10", 13'h010, 1'b1, 13'h080);

        // Alias on the same index replaces the entry.
        upd(13'h050, 13'h200, 1'b1, 1'b1);
        expect_lookup("alias_old", 13'h010, 1'b0, 13'h011);
        expect_lookup("alias_new", 13'h050, 1'b1, 13'h200);

        // Same-cycle lookup and allocate: no bypass.
        bp_if.pc = 13'h020; bp_if.upd_valid = 1'b1; bp_if.upd_pc = 13'h020;
        bp_if.upd_target = 13'h123; bp_if.upd_taken = 1'b1; bp_if.upd_mispredict = 1'b0;
        #1;
        check_val("same_cyc_hit", {31'd0, bp_if.hit_predict}, 32'd0);
        @(posedge CLK);
        model_update(13'h020, 13'h123, 1'b1, 1'b0);
        @(negedge CLK);
        expect_lookup("next_cyc", 13'h020, 1'b1, 13'h123);

        // Random traffic concentrated on a few indices so tags alias often.
        for (int n = 0; n < 400; n++) begin
            rpc  = 13'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
            rupc = 13'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
            rtgt = 13'($urandom_range(0, 8191));
            if ($urandom_range(0, 9) == 0) rpc = 13'($urandom_range(0, 8191));
            cycle(rpc, 1'($urandom_range(0, 1)), rupc, rtgt,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
        end

        // Perf counters from a clean reset: 5 updates, 2 mispredicts.
        async_reset_pulse();
        upd(13'h030, 13'h100, 1'b1, 1'b1);
        upd(13'h031, 13'h101, 1'b0, 1'b0);
        upd(13'h030, 13'h102, 1'b1, 1'b0);
        upd(13'h032, 13'h103, 1'b1, 1'b1);
        upd(13'h033, 13'h104, 1'b0, 1'b0);
        check_val("perf5", bp_if.perf_branches, PERF_EN ? 32'd5 : 32'd0);
        check_val("perf2", bp_if.perf_mispred,  PERF_EN ? 32'd2 : 32'd0);
        async_reset_pulse();
        expect_lookup("post_rst", 13'h030, 1'b0, 13'h031);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
